// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-master memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic STROBE_ASSERT  = 1'b0;
    localparam logic STROBE_RELEASE = 1'b1;

    localparam logic ACK_PULSE = 1'b1;
    localparam logic ACK_IDLE  = 1'b0;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker: masked requests, ties go to the port that
// was not granted last.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req & ~mask;
        valid    = |eligible;
        winner   = PORT_CPU;
        if (&eligible) begin
            winner = other_port(last_grant);
        end else if (eligible[PORT_DMA]) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one strobe-driven memory bus between the CPU (port 0) and DMA
// (port 1), sequencing setup, strobe and hold for each access.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW            = 16,
    parameter int DW            = 8,
    parameter int STROBE_CYCLES = 1
) (
    input  logic          cpu_clk,
    input  logic          cpu_reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_o,
    input  logic [DW-1:0] mem_data_i,
    output logic          mem_oe_n,
    output logic          mem_we_n
);

    localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_STROBE = CW'(STROBE_CYCLES - 1);

    arb_state_t    state_q, state_d;
    logic [CW-1:0] strobe_cnt;
    logic          last_grant;
    logic          grant;
    logic          we_q;
    logic          load;
    logic          read_done;
    logic [1:0]    arb_mask;
    logic          arb_valid;
    logic          arb_winner;
    logic          cur_req;
    logic          cur_we;
    logic [AW-1:0] cur_addr;

    // During HOLD the port being acknowledged is excluded from arbitration.
    always_comb begin
        arb_mask = 2'b00;
        if (state_q == ST_HOLD) begin
            arb_mask[grant] = 1'b1;
        end
    end

    mem_arb_rr2 u_rr2 (
        .req        ({p1_req, p0_req}),
        .mask       (arb_mask),
        .last_grant (last_grant),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_SETUP;
                    load    = 1'b1;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: begin
                if (strobe_cnt == LAST_STROBE) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (arb_valid) begin
                    state_d = ST_SETUP;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign read_done = (state_q == ST_STROBE) && (state_d == ST_HOLD) && !we_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            state_q    <= ST_IDLE;
            strobe_cnt <= '0;
        end else begin
            state_q    <= state_d;
            strobe_cnt <= (state_q == ST_STROBE) ? strobe_cnt + CW'(1) : '0;
        end
    end

    // Strobes and acks are registered from the next state so they line up
    // exactly with the STROBE and HOLD cycles.
    always_ff @(posedge cpu_clk) begin
        if (cpu_reset) begin
            last_grant <= PORT_DMA;
            grant      <= PORT_CPU;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_data_o <= '0;
            mem_oe_n   <= STROBE_RELEASE;
            mem_we_n   <= STROBE_RELEASE;
            p0_ack     <= ACK_IDLE;
            p1_ack     <= ACK_IDLE;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            mem_oe_n <= (state_d == ST_STROBE && !we_q) ? STROBE_ASSERT : STROBE_RELEASE;
            mem_we_n <= (state_d == ST_STROBE &&  we_q) ? STROBE_ASSERT : STROBE_RELEASE;
            p0_ack   <= (state_d == ST_HOLD && grant == PORT_CPU) ? ACK_PULSE : ACK_IDLE;
            p1_ack   <= (state_d == ST_HOLD && grant == PORT_DMA) ? ACK_PULSE : ACK_IDLE;

            if (load) begin
                grant      <= arb_winner;
                last_grant <= arb_winner;
                if (arb_winner == PORT_DMA) begin
                    mem_addr   <= p1_addr;
                    mem_data_o <= p1_wdata;
                    we_q       <= p1_we;
                end else begin
                    mem_addr   <= p0_addr;
                    mem_data_o <= p0_wdata;
                    we_q       <= p0_we;
                end
            end

            if (read_done) begin
                if (grant == PORT_DMA) begin
                    p1_rdata <= mem_data_i;
                end else begin
                    p0_rdata <= mem_data_i;
                end
            end
        end
    end

    assign cur_req  = (grant == PORT_DMA) ? p1_req  : p0_req;
    assign cur_we   = (grant == PORT_DMA) ? p1_we   : p0_we;
    assign cur_addr = (grant == PORT_DMA) ? p1_addr : p0_addr;

    // A granted master must keep its transaction steady until acknowledged;
    // the latched copy is what actually goes to memory.
    assert property (@(posedge cpu_clk) disable iff (cpu_reset)
        ((state_q == ST_SETUP || state_q == ST_STROBE) && cur_req)
            |-> (cur_addr == mem_addr && cur_we == we_q));

endmodule
